// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with per-register pending-write counters,
// optional same-cycle writeback bypass and an issue-ready handshake for the IDU.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREG   = 16,
    parameter int AW     = 4,
    parameter int NRD    = 2,
    parameter int CNTW   = 2,
    parameter int BYPASS = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   raddr,
    input  logic [NRD-1:0]      ren,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic                issue_valid,
    input  logic                issue_wen,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);

    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [AW-1:0]   X0       = {AW{1'b0}};

    logic [XLEN-1:0] regs_r [NREG];
    logic [CNTW-1:0] cnt_r  [NREG];
    logic [CNTW-1:0] eff_s  [NREG];
    logic [NREG-1:0] inc_s;
    logic [NREG-1:0] dec_s;
    logic            wb_we_s;
    logic            raw_s;
    logic            struct_s;
    logic            fire_s;

    assign wb_we_s = wb_valid && (wb_rd != X0);

    // Effective count: a bypassed writeback retires its pending write early
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            if ((BYPASS != 0) && wb_we_s && (wb_rd == AW'(i)) && (cnt_r[i] != CNT_ZERO)) begin
                eff_s[i] = cnt_r[i] - CNT_ONE;
            end else begin
                eff_s[i] = cnt_r[i];
            end
        end
    end

    // Combinational read ports and per-port RAW hazard detection
    always_comb begin
        rdata = {(NRD*XLEN){1'b0}};
        raw_s = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            if (raddr[k*AW +: AW] == X0) begin
                rdata[k*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if ((BYPASS != 0) && wb_we_s && (wb_rd == raddr[k*AW +: AW])) begin
                rdata[k*XLEN +: XLEN] = wb_data;
            end else begin
                rdata[k*XLEN +: XLEN] = regs_r[raddr[k*AW +: AW]];
            end
            if (ren[k] && (raddr[k*AW +: AW] != X0) && (eff_s[raddr[k*AW +: AW]] != CNT_ZERO)) begin
                raw_s = 1'b1;
            end else begin
                raw_s = raw_s;
            end
        end
    end

    // Ready never looks at issue_valid, so the IDU handshake has no loop
    assign struct_s    = issue_wen && (issue_rd != X0) && (eff_s[issue_rd] == CNT_MAX);
    assign issue_ready = !raw_s && !struct_s;
    assign fire_s      = issue_valid && issue_ready && !flush;

    // Per-register increment/decrement requests and busy view of the counters
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            inc_s[i]    = fire_s && issue_wen && (issue_rd != X0) && (issue_rd == AW'(i));
            dec_s[i]    = wb_we_s && (wb_rd == AW'(i)) && (cnt_r[i] != CNT_ZERO);
            busy_vec[i] = (cnt_r[i] != CNT_ZERO);
        end
    end

    // Pending-write counters; flush clears them, a decrement at zero saturates
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else if (flush) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                case ({inc_s[i], dec_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CNT_ONE;
                    2'b01:   cnt_r[i] <= cnt_r[i] - CNT_ONE;
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

    // Register array; writebacks land even when a flush coincides
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_we_s) begin
            regs_r[wb_rd] <= wb_data;
        end else begin
            regs_r[wb_rd] <= regs_r[wb_rd];
        end
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised integer register file with a per-register pending-write scoreboard, optional writeback bypass and an issue-ready handshake toward the IDU.
- Generalises the existing fixed 16x32, 2-read-port register file with its rd-compare hazard check: configurable register count, width and read-port count.
- Hazard tracking uses saturating per-register outstanding-write counters instead of fixed EXU/WBU rd comparisons, so it stays correct for any pipeline depth.
- Sits between IDU (reads, issue) and WBU (writes).

Parameters:
- XLEN, 32, register data width
- NREG, 16, number of architectural registers (x0 included); power of two
- AW, 4, register address width; must equal log2(NREG)
- NRD, 2, number of read ports
- CNTW, 2, width of each pending-write counter; max outstanding writes per register = 2^CNTW-1
- BYPASS, 1, 1 = forward same-cycle writeback data to read ports and to the hazard check

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- raddr  in  NRD*AW  read addresses, port k at [k*AW +: AW]
- ren  in  NRD  port k is a real source operand for the issuing instruction
- rdata  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
- issue_valid  in  1  IDU presents an instruction
- issue_wen  in  1  instruction writes a destination
- issue_rd  in  AW  destination register
- issue_ready  out  1  no hazard; issue fires on issue_valid && issue_ready
- wb_valid  in  1  writeback this cycle
- wb_rd  in  AW  writeback destination
- wb_data  in  XLEN  writeback data
- flush  in  1  discard all pending-write tracking
- busy_vec  out  NREG  bit i = cnt[i] != 0 (debug/perf)

Behaviour:
- Reset (synchronous, active-high): all registers 0, all counters 0. Outputs after reset: busy_vec = 0, rdata = 0, issue_ready = 1 unless a read port with ren=1 targets a busy register (none after reset). Reset overrides issue, wb and flush in the same cycle.
- x0: always reads 0, never written, counter held at 0, never busy.
- Reads are combinational.
  - rdata[k] = wb_data if BYPASS && wb_valid && wb_rd == raddr[k] && raddr[k] != 0; otherwise the array value.
  - With BYPASS = 0 the written value is visible the cycle after wb_valid.
- Writeback: wb_valid && wb_rd != 0 writes the array at the clock edge.
  - cnt[wb_rd] decrements by 1 if nonzero.
  - If the counter is already 0 it stays 0; the data is still written. This occurs after a flush and is legal.
- Issue fire = issue_valid && issue_ready && !flush. On fire with issue_wen && issue_rd != 0, cnt[issue_rd] increments.
- Same cycle, same register, fire-increment and wb-decrement both apply: the counter is unchanged.
- Effective count: eff[r] = cnt[r] - 1 if BYPASS && wb_valid && wb_rd == r && cnt[r] != 0; otherwise eff[r] = cnt[r].
- RAW hazard on port k: ren[k] && raddr[k] != 0 && eff[raddr[k]] != 0.
- Structural hazard: issue_wen && issue_rd != 0 && eff[issue_rd] == 2^CNTW-1.
- issue_ready = no RAW hazard on any port && no structural hazard. It is independent of issue_valid (no combinational loop on issue_valid).
- WAW is allowed up to the counter limit. Writebacks to the same register must arrive in issue order; the pipeline guarantees this.
- Flush: all counters cleared at the edge.
  - A coincident issue is not counted.
  - A coincident writeback still writes data.
  - issue_ready during the flush cycle is computed normally but ignored.
- busy_vec is registered-state derived: it reflects counters after the last edge, not eff.

Test Plan:
- Reset, then read x0..x15 with ren=11 -> all rdata 0, issue_ready=1, busy_vec=0.
- Issue wen rd=5; next cycle raddr0=5 ren0=1 -> issue_ready=0, busy_vec=0x0020. Then wb rd=5 data=0xDEADBEEF with BYPASS=1 -> same cycle rdata0=0xDEADBEEF, issue_ready=1; next cycle busy_vec=0.
- CNTW=2: issue rd=3 three times with no wb -> 4th issue_wen rd=3 sees issue_ready=0. Wb rd=3 in the same cycle -> issue_ready=1, counter stays 3.
- Source x0 while "rd=0" issues repeatedly -> counter never moves, issue_ready=1, rdata=0. Wb rd=0 data=0x1 -> x0 still reads 0.
- Issue rd=7, rd=9 pending, then flush with a simultaneous issue rd=2 -> next cycle busy_vec=0. A later wb rd=7 data=0x55 -> x7=0x55, counter stays 0.
- BYPASS=0: wb rd=4 data=0xA5A5A5A5 with raddr1=4 -> same cycle old x4 value and issue_ready=0 if ren1. Next cycle 0xA5A5A5A5 and issue_ready=1.
